// File: rtl/disp_seq_if.sv
// Display-bus checker port bundle: the table load, control and observed bus come in,
// and the verdict goes out.
interface disp_seq_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 8,
    parameter int SEL_W  = 6
);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [SEL_W-1:0]  sel;
    logic              exp_we;
    logic [IW-1:0]     exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [LW-1:0]     seq_len;
    logic              start;
    logic              clear;
    logic [DATA_W-1:0] disp;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              done;
    logic              pass;
    logic [1:0]        fail_code;
    logic [IW-1:0]     cur_idx;
    logic [PC_W-1:0]   cap_pc;
    logic [DATA_W-1:0] cap_data;

    modport master (
        output sel, exp_we, exp_addr, exp_data, seq_len, start, clear, disp, pc,
        input  busy, done, pass, fail_code, cur_idx, cap_pc, cap_data
    );

    modport slave (
        input  sel, exp_we, exp_addr, exp_data, seq_len, start, clear, disp, pc,
        output busy, done, pass, fail_code, cur_idx, cap_pc, cap_data
    );
endinterface

// File: rtl/disp_seq_checker.sv
// On-chip monitor: the display word must walk through a programmable table in order.
// It reports pass/fail with the PC and data seen at the deciding sample.
module disp_seq_checker #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 8,
    parameter int SEL_W   = 6,
    parameter int SEL_VAL = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic     clk,
    input  logic     reset,
    disp_seq_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] tab [DEPTH];
    logic [IW-1:0]     idx, idx_n;
    logic [LW-1:0]     len, len_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              first, first_n;
    logic [1:0]        code, code_n;
    logic [PC_W-1:0]   cpc, cpc_n;
    logic [DATA_W-1:0] cdat, cdat_n;
    logic [LW-1:0]     idx_p1;
    logic              hit_cur, hit_nxt, decide, enabled;

    // Table has no reset; loads are locked out while a check is running.
    always_ff @(posedge clk) begin
        if (bus.exp_we && state != RUN)
            tab[bus.exp_addr] <= bus.exp_data;
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_n   = len;
        cnt_n   = cnt;
        first_n = first;
        code_n  = code;
        cpc_n   = cpc;
        cdat_n  = cdat;
        decide  = 1'b0;
        enabled = (bus.sel == SEL_W'(SEL_VAL));
        idx_p1  = LW'(idx) + LW'(1);
        hit_cur = (bus.disp == tab[idx]);
        hit_nxt = (idx_p1 < len) && (bus.disp == tab[IW'(idx_p1)]);

        if (bus.clear) begin
            state_n = IDLE;
            idx_n   = '0;
            len_n   = '0;
            cnt_n   = '0;
            first_n = 1'b0;
            code_n  = 2'd0;
            cpc_n   = '0;
            cdat_n  = '0;
        end else begin
            case (state)
                IDLE, PASS, FAIL: begin
                    if (bus.start) begin
                        idx_n   = '0;
                        cnt_n   = '0;
                        code_n  = 2'd0;
                        cpc_n   = '0;
                        cdat_n  = '0;
                        if (bus.seq_len == '0 || bus.seq_len > LW'(DEPTH)) begin
                            state_n = FAIL;
                            code_n  = 2'd3;
                            first_n = 1'b0;
                        end else begin
                            state_n = RUN;
                            len_n   = bus.seq_len;
                            first_n = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (enabled) begin
                        // While first is set idx is 0, so hit_cur compares against entry 0.
                        if (first) begin
                            if (hit_cur) begin
                                first_n = 1'b0;
                                cnt_n   = '0;
                                if (len == LW'(1)) begin
                                    state_n = PASS;
                                    decide  = 1'b1;
                                end
                            end else begin
                                state_n = FAIL;
                                code_n  = 2'd1;
                                decide  = 1'b1;
                            end
                        end else if (hit_cur) begin
                            if (cnt >= CW'(TIMEOUT - 1)) begin
                                state_n = FAIL;
                                code_n  = 2'd2;
                                decide  = 1'b1;
                            end else begin
                                cnt_n = cnt + CW'(1);
                            end
                        end else if (hit_nxt) begin
                            idx_n = IW'(idx_p1);
                            cnt_n = '0;
                            if (idx_p1 == len - LW'(1)) begin
                                state_n = PASS;
                                decide  = 1'b1;
                            end
                        end else begin
                            state_n = FAIL;
                            code_n  = 2'd1;
                            decide  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (decide) begin
            cpc_n  = bus.pc;
            cdat_n = bus.disp;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            len   <= '0;
            cnt   <= '0;
            first <= 1'b0;
            code  <= 2'd0;
            cpc   <= '0;
            cdat  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            len   <= len_n;
            cnt   <= cnt_n;
            first <= first_n;
            code  <= code_n;
            cpc   <= cpc_n;
            cdat  <= cdat_n;
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == PASS) || (state == FAIL);
    assign bus.pass      = (state == PASS);
    assign bus.fail_code = code;
    assign bus.cur_idx   = idx;
    assign bus.cap_pc    = cpc;
    assign bus.cap_data  = cdat;
endmodule

// File: tb/tb_disp_seq_checker.sv
// Directed plus randomized bench for disp_seq_checker against a history-scanning model.
module tb_disp_seq_checker;
    localparam int DATA_W  = 32;
    localparam int PC_W    = 32;
    localparam int DEPTH   = 8;
    localparam int SEL_W   = 6;
    localparam int SEL_VAL = 2;
    localparam int TIMEOUT = 16;
    localparam int IW      = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    disp_seq_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) bus ();

    disp_seq_checker #(
        .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .SEL_W(SEL_W),
        .SEL_VAL(SEL_VAL), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [PC_W-1:0]   p;
    } samp_t;

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 run, 2 pass, 3 fail
    int                m_st, m_len, m_idx, m_code;
    logic [PC_W-1:0]   m_cpc;
    logic [DATA_W-1:0] m_cdat;
    logic [DATA_W-1:0] tab_m [DEPTH];
    samp_t             hist[$];

    function automatic void m_zero();
        m_st = 0; m_len = 0; m_idx = 0; m_code = 0; m_cpc = '0; m_cdat = '0;
        hist.delete();
    endfunction

    // Replays every enabled sample since start; the walk's outcome is the expected state.
    function automatic void eval();
        int idx = 0;
        int since = 0;
        int verdict;
        m_st = 1;
        foreach (hist[i]) begin
            logic [DATA_W-1:0] d = hist[i].d;
            verdict = 0;
            if (i == 0) begin
                if (d != tab_m[0]) verdict = 1;
                else if (m_len == 1) verdict = 4;
            end else if (d == tab_m[idx]) begin
                since++;
                if (since >= TIMEOUT) verdict = 2;
            end else if (idx + 1 < m_len && d == tab_m[idx + 1]) begin
                idx++;
                since = 0;
                if (idx == m_len - 1) verdict = 4;
            end else begin
                verdict = 1;
            end
            if (verdict != 0) begin
                m_st   = (verdict == 4) ? 2 : 3;
                m_code = (verdict == 4) ? 0 : verdict;
                m_cpc  = hist[i].p;
                m_cdat = d;
                break;
            end
        end
        m_idx = idx;
    endfunction

    task automatic check_all(input string tag);
        logic [71:0] act, exp;
        act = {bus.busy, bus.done, bus.pass, bus.fail_code, bus.cur_idx, bus.cap_pc, bus.cap_data};
        exp = {(m_st == 1), (m_st >= 2), (m_st == 2), 2'(m_code), IW'(m_idx), m_cpc, m_cdat};
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies one clock: model update from the pre-edge inputs, then compare after the edge.
    task automatic cyc(input string tag);
        int pre = m_st;
        if (bus.exp_we && pre != 1) tab_m[bus.exp_addr] = bus.exp_data;
        if (bus.clear) begin
            m_zero();
        end else if (bus.start && pre != 1) begin
            m_code = 0; m_cpc = '0; m_cdat = '0; m_idx = 0;
            hist.delete();
            if (bus.seq_len == 0 || int'(bus.seq_len) > DEPTH) begin
                m_st = 3; m_code = 3;
            end else begin
                m_st = 1; m_len = int'(bus.seq_len);
            end
        end else if (pre == 1 && bus.sel == SEL_W'(SEL_VAL)) begin
            hist.push_back('{bus.disp, bus.pc});
            eval();
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic load(input logic [DATA_W-1:0] v [DEPTH], input int n);
        for (int i = 0; i < n; i++) begin
            bus.exp_we = 1'b1; bus.exp_addr = IW'(i); bus.exp_data = v[i];
            cyc("load");
        end
        bus.exp_we = 1'b0;
    endtask

    task automatic go(input int n);
        bus.seq_len = 4'(n); bus.start = 1'b1;
        cyc("start");
        bus.start = 1'b0;
    endtask

    task automatic samp(input logic [DATA_W-1:0] d, input logic [PC_W-1:0] p, input int s);
        bus.disp = d; bus.pc = p; bus.sel = SEL_W'(s);
        cyc("sample");
    endtask

    initial begin
        logic [DATA_W-1:0] t1 [DEPTH];
        logic [DATA_W-1:0] tr [DEPTH];
        m_zero();
        bus.sel = SEL_W'(SEL_VAL); bus.exp_we = 1'b0; bus.exp_addr = '0; bus.exp_data = '0;
        bus.seq_len = '0; bus.start = 1'b0; bus.clear = 1'b0; bus.disp = '0; bus.pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;

        // 1: the classic 0/1/2/6/24 sequence with repeats
        t1 = '{0, 1, 2, 6, 24, 0, 0, 0};
        load(t1, DEPTH);
        go(5);
        foreach (t1[i]) if (i < 5) begin
            if (i != 4) samp(t1[i], 32'h10 + i, SEL_VAL);
            if (i == 0 || i == 1 || i == 3) samp(t1[i], 32'h20 + i, SEL_VAL);
        end
        samp(24, 32'h40, SEL_VAL);
        chk("t1_pass", 32'(bus.pass), 1);
        chk("t1_idx", 32'(bus.cur_idx), 4);
        chk("t1_cap_data", bus.cap_data, 24);
        chk("t1_cap_pc", bus.cap_pc, 32'h40);

        // 2: mismatch after advancing to index 1
        go(5);
        samp(0, 32'h14, SEL_VAL);
        samp(1, 32'h18, SEL_VAL);
        samp(5, 32'h1C, SEL_VAL);
        chk("t2_code", 32'(bus.fail_code), 1);
        chk("t2_cap_data", bus.cap_data, 5);
        chk("t2_cap_pc", bus.cap_pc, 32'h1C);
        chk("t2_idx", 32'(bus.cur_idx), 1);

        // 3: stuck value runs into the timeout
        go(5);
        samp(0, 0, SEL_VAL); samp(1, 0, SEL_VAL); samp(2, 0, SEL_VAL);
        repeat (TIMEOUT - 1) samp(2, 32'h30, SEL_VAL);
        chk("t3_not_yet", 32'(bus.busy), 1);
        samp(2, 32'h34, SEL_VAL);
        chk("t3_code", 32'(bus.fail_code), 2);

        // 4: selector off freezes progress and the timeout
        go(5);
        samp(0, 0, SEL_VAL); samp(1, 0, SEL_VAL); samp(2, 0, SEL_VAL);
        repeat (100) samp(99, 32'h50, 3);
        chk("t4_hold_idx", 32'(bus.cur_idx), 2);
        chk("t4_hold_busy", 32'(bus.busy), 1);
        samp(6, 0, SEL_VAL); samp(24, 32'h60, SEL_VAL);
        chk("t4_pass", 32'(bus.pass), 1);

        // 5: write locked out in RUN, then config failures
        go(5);
        samp(0, 0, SEL_VAL);
        bus.exp_we = 1'b1; bus.exp_addr = '0; bus.exp_data = 555;
        samp(1, 0, SEL_VAL);
        bus.exp_we = 1'b0;
        bus.clear = 1'b1; cyc("clear"); bus.clear = 1'b0;
        go(0);
        chk("t5_len0", 32'(bus.fail_code), 3);
        chk("t5_len0_cap", bus.cap_data | bus.cap_pc, 0);
        go(9);
        chk("t5_len9", 32'(bus.fail_code), 3);
        go(5);
        samp(0, 0, SEL_VAL);
        chk("t5_table_kept", 32'(bus.busy), 1);

        // 6: asynchronous reset mid-run, then a one-entry check
        #2 reset = 1'b0;
        #1;
        m_zero();
        check_all("async_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        tr = '{7, 0, 0, 0, 0, 0, 0, 0};
        load(tr, 1);
        go(1);
        samp(7, 32'h70, SEL_VAL);
        chk("t6_pass", 32'(bus.pass), 1);

        // Randomized runs over small value ranges so repeats and collisions occur
        for (int r = 0; r < 25; r++) begin
            int n = $urandom_range(1, DEPTH);
            foreach (tr[i]) tr[i] = $urandom_range(0, 7);
            load(tr, DEPTH);
            go(n);
            for (int c = 0; c < 80 && m_st == 1; c++) begin
                int k = $urandom_range(0, 7);
                logic [DATA_W-1:0] d;
                d = (k < 4) ? tab_m[m_idx] : (k < 7) ? tab_m[(m_idx + 1) % DEPTH] : $urandom_range(0, 7);
                bus.clear = ($urandom_range(0, 59) == 0);
                bus.exp_we = ($urandom_range(0, 9) == 0);
                bus.exp_addr = IW'($urandom_range(0, DEPTH - 1));
                bus.exp_data = $urandom_range(0, 7);
                samp(d, $urandom, ($urandom_range(0, 4) == 0) ? $urandom_range(3, 63) : SEL_VAL);
                bus.clear = 1'b0; bus.exp_we = 1'b0;
            end
            if (m_st == 1) begin
                bus.clear = 1'b1; cyc("rand_clear"); bus.clear = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
